// File: rtl/dmem_sram_bridge.sv
// Data-memory bridge: turns the merged E-stage memory request into a single
// outstanding SRAM-like bus transaction, returns the aligned load result and holds the LL/SC link bit.
`ifndef OP_LB
`define OP_LB  6'h20
`endif
`ifndef OP_LH
`define OP_LH  6'h21
`endif
`ifndef OP_LW
`define OP_LW  6'h23
`endif
`ifndef OP_LBU
`define OP_LBU 6'h24
`endif
`ifndef OP_LHU
`define OP_LHU 6'h25
`endif
`ifndef OP_SB
`define OP_SB  6'h28
`endif
`ifndef OP_SH
`define OP_SH  6'h29
`endif
`ifndef OP_SW
`define OP_SW  6'h2b
`endif
`ifndef OP_LL
`define OP_LL  6'h30
`endif
`ifndef OP_SC
`define OP_SC  6'h38
`endif

module dmem_sram_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        E_mem_en,
   input  logic        E_mem_ren,
   input  logic        E_mem_wen,
   input  logic [5:0]  E_mem_op,
   input  logic [31:0] E_mem_addr,
   input  logic [31:0] E_mem_wdata,
   input  logic        E_flush,
   input  logic        M_ena,
   input  logic        llbit_clr,
   output logic        d_stall,
   output logic [31:0] M_mem_rdata,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic [1:0]  state_dbg
);

   // Bus handshake: data_req stays high with stable fields until data_addr_ok is
   // sampled high; the single outstanding access then completes on data_data_ok.
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t      state, state_nxt;
   logic [5:0]  op_q;
   logic        ren_q;
   logic [31:0] result;
   logic        llbit;
   logic        cancel;
   logic        accept, sc_fail, finish, cancel_now;
   logic [1:0]  enc_size;
   logic [3:0]  enc_wstrb;
   logic [31:0] enc_wdata;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;

   assign accept     = (state == IDLE) && E_mem_en && !E_flush;
   assign sc_fail    = accept && (E_mem_op == `OP_SC) && !llbit;
   assign finish     = (state == WAIT) && data_data_ok;
   // A flush arriving on the very cycle the data returns also counts as a cancel.
   assign cancel_now = cancel || E_flush;

   assign data_req    = (state == REQ);
   assign M_mem_rdata = result;
   assign state_dbg   = state;

   always_comb begin
      state_nxt = state;
      d_stall   = 1'b0;
      case (state)
         IDLE: begin
            d_stall = E_mem_en && !E_flush;
            if (accept) state_nxt = sc_fail ? DONE : REQ;
         end
         REQ: begin
            d_stall = 1'b1;
            if (data_addr_ok) state_nxt = WAIT;
         end
         WAIT: begin
            d_stall = 1'b1;
            if (data_data_ok) state_nxt = cancel_now ? IDLE : DONE;
         end
         DONE: if (M_ena) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      enc_size  = 2'd2;
      enc_wstrb = 4'b1111;
      enc_wdata = E_mem_wdata;
      case (E_mem_op)
         `OP_SB, `OP_LB, `OP_LBU: begin
            enc_size  = 2'd0;
            enc_wstrb = 4'b0001 << E_mem_addr[1:0];
            enc_wdata = {4{E_mem_wdata[7:0]}};
         end
         `OP_SH, `OP_LH, `OP_LHU: begin
            enc_size  = 2'd1;
            enc_wstrb = E_mem_addr[1] ? 4'b1100 : 4'b0011;
            enc_wdata = {2{E_mem_wdata[15:0]}};
         end
         default: ;
      endcase
      if (!E_mem_wen) enc_wstrb = 4'b0000;
   end

   always_comb begin
      case (data_addr[1:0])
         2'd0:    byte_sel = data_rdata[7:0];
         2'd1:    byte_sel = data_rdata[15:8];
         2'd2:    byte_sel = data_rdata[23:16];
         default: byte_sel = data_rdata[31:24];
      endcase
      half_sel = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (op_q)
         `OP_LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
         `OP_LBU: load_val = {24'd0, byte_sel};
         `OP_LH:  load_val = {{16{half_sel[15]}}, half_sel};
         `OP_LHU: load_val = {16'd0, half_sel};
         default: load_val = data_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= 6'd0;
         ren_q      <= 1'b0;
         data_wr    <= 1'b0;
         data_size  <= 2'd0;
         data_wstrb <= 4'd0;
         data_addr  <= 32'd0;
         data_wdata <= 32'd0;
      end else if (accept) begin
         op_q       <= E_mem_op;
         ren_q      <= E_mem_ren;
         data_wr    <= E_mem_wen;
         data_size  <= enc_size;
         data_wstrb <= enc_wstrb;
         data_addr  <= E_mem_addr;
         data_wdata <= enc_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= 32'd0;
         llbit  <= 1'b0;
         cancel <= 1'b0;
      end else begin
         if (sc_fail) result <= 32'd0;
         else if (finish && !cancel_now) begin
            if (ren_q)                result <= load_val;
            else if (op_q == `OP_SC)  result <= 32'd1;
         end
         // llbit_clr has priority over a completing LL in the same cycle.
         if (llbit_clr) llbit <= 1'b0;
         else if (finish && !cancel_now && ren_q && (op_q == `OP_LL)) llbit <= 1'b1;
         if (finish)                                         cancel <= 1'b0;
         else if (((state == REQ) || (state == WAIT)) && E_flush) cancel <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: directed cases plus random traffic against
// a word-array memory model, with a randomly delayed bus responder and result scoreboard.
`ifndef OP_LB
`define OP_LB  6'h20
`endif
`ifndef OP_LH
`define OP_LH  6'h21
`endif
`ifndef OP_LW
`define OP_LW  6'h23
`endif
`ifndef OP_LBU
`define OP_LBU 6'h24
`endif
`ifndef OP_LHU
`define OP_LHU 6'h25
`endif
`ifndef OP_SB
`define OP_SB  6'h28
`endif
`ifndef OP_SH
`define OP_SH  6'h29
`endif
`ifndef OP_SW
`define OP_SW  6'h2b
`endif
`ifndef OP_LL
`define OP_LL  6'h30
`endif
`ifndef OP_SC
`define OP_SC  6'h38
`endif

module tb_dmem_sram_bridge;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        E_mem_en = 1'b0, E_mem_ren = 1'b0, E_mem_wen = 1'b0;
   logic [5:0]  E_mem_op = 6'd0;
   logic [31:0] E_mem_addr = 32'd0, E_mem_wdata = 32'd0;
   logic        E_flush = 1'b0, M_ena = 1'b0, llbit_clr = 1'b0;
   logic        d_stall;
   logic [31:0] M_mem_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [1:0]  state_dbg;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   bus_t        bus_q[$];
   logic [31:0] ref_mem[128];
   logic [31:0] bus_mem[128];
   logic [31:0] res_model = 32'd0;
   logic        ll_model = 1'b0;
   int          next_a = 0, next_d = 0;

   dmem_sram_bridge dut (
      .clk(clk), .rst(rst),
      .E_mem_en(E_mem_en), .E_mem_ren(E_mem_ren), .E_mem_wen(E_mem_wen),
      .E_mem_op(E_mem_op), .E_mem_addr(E_mem_addr), .E_mem_wdata(E_mem_wdata),
      .E_flush(E_flush), .M_ena(M_ena), .llbit_clr(llbit_clr),
      .d_stall(d_stall), .M_mem_rdata(M_mem_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic is_load(input logic [5:0] op);
      return op == `OP_LB || op == `OP_LBU || op == `OP_LH || op == `OP_LHU ||
             op == `OP_LW || op == `OP_LL;
   endfunction

   // ---------------- bus responder ----------------
   initial begin : responder
      int   a_cnt;
      int   d_cnt;
      logic in_flight;
      bus_t snap, cur, act, exp;
      logic [6:0] idx;
      a_cnt = -1; d_cnt = 0; in_flight = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         if (rst) begin
            a_cnt = -1; in_flight = 1'b0;
         end else if (in_flight) begin
            if (d_cnt == 0) begin
               idx = cur.addr[8:2];
               data_data_ok = 1'b1;
               data_rdata = cur.wr ? $urandom : bus_mem[idx];
               if (cur.wr)
                  for (int k = 0; k < 4; k++)
                     if (cur.wstrb[k]) bus_mem[idx][8*k +: 8] = cur.wdata[8*k +: 8];
               in_flight = 1'b0;
            end else d_cnt--;
         end else if (data_req) begin
            act = '{data_addr, data_wr, data_size, data_wstrb, data_wdata};
            if (a_cnt < 0) begin
               a_cnt = next_a;
               snap  = act;
            end else begin
               check("req_fields_stable", act[70:39], snap[70:39]);
               check("req_wdata_stable", act.wdata, snap.wdata);
            end
            if (a_cnt == 0) begin
               data_addr_ok = 1'b1;
               cur = act; in_flight = 1'b1; d_cnt = next_d; a_cnt = -1;
               if (bus_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
               else begin
                  exp = bus_q.pop_front();
                  if (!exp.wr) act.wdata = 32'd0;
                  check("bus_addr", act.addr, exp.addr);
                  check("bus_ctrl", {25'd0, act.wr, act.size, act.wstrb},
                                    {25'd0, exp.wr, exp.size, exp.wstrb});
                  check("bus_wdata", act.wdata, exp.wdata);
               end
            end else a_cnt--;
         end
      end
   end

   // ---------------- result monitor ----------------
   initial begin : monitor
      logic [31:0] exp;
      forever begin
         @(negedge clk);
         if (!rst && state_dbg == 2'd3 && M_ena) begin
            if (exp_q.size() == 0) check("result_unexpected", 32'd1, 32'd0);
            else begin
               exp = exp_q.pop_front();
               check("M_mem_rdata", M_mem_rdata, exp);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic model_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           output logic to_bus, output bus_t b);
      logic [6:0]  idx;
      int          off;
      logic [31:0] word, v, mask;
      idx = addr[8:2];
      off = int'(addr[1:0]);
      word = ref_mem[idx];
      to_bus = 1'b1;
      b.addr = addr;
      b.wr = !is_load(op);
      b.size = (op == `OP_LB || op == `OP_LBU || op == `OP_SB) ? 2'd0 :
               (op == `OP_LH || op == `OP_LHU || op == `OP_SH) ? 2'd1 : 2'd2;
      b.wstrb = 4'd0;
      b.wdata = 32'd0;
      case (op)
         `OP_LB, `OP_LBU: begin
            v = (word >> (8 * off)) & 32'hFF;
            if (op == `OP_LB && v >= 32'h80) v = v + 32'hFFFF_FF00;
            res_model = v;
         end
         `OP_LH, `OP_LHU: begin
            v = (word >> (8 * off)) & 32'hFFFF;
            if (op == `OP_LH && v >= 32'h8000) v = v + 32'hFFFF_0000;
            res_model = v;
         end
         `OP_LW: res_model = word;
         `OP_LL: begin res_model = word; ll_model = 1'b1; end
         `OP_SB: begin
            mask = 32'hFF << (8 * off);
            ref_mem[idx] = (word & ~mask) | ((wd & 32'hFF) << (8 * off));
            b.wstrb = 4'(1 << off);
            b.wdata = (wd & 32'hFF) * 32'h0101_0101;
         end
         `OP_SH: begin
            mask = 32'hFFFF << (8 * off);
            ref_mem[idx] = (word & ~mask) | ((wd & 32'hFFFF) << (8 * off));
            b.wstrb = 4'(3 << off);
            b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
         end
         `OP_SW: begin ref_mem[idx] = wd; b.wstrb = 4'hF; b.wdata = wd; end
         default: begin
            if (ll_model) begin
               ref_mem[idx] = wd; b.wstrb = 4'hF; b.wdata = wd; res_model = 32'd1;
            end else begin
               to_bus = 1'b0; res_model = 32'd0;
            end
         end
      endcase
   endtask

   // ---------------- driver tasks (entered/left at posedge+1) ----------------
   task automatic drive_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
      E_mem_en = 1'b1; E_mem_op = op; E_mem_addr = addr; E_mem_wdata = wd;
      E_mem_ren = is_load(op); E_mem_wen = !is_load(op);
   endtask

   task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int a, input int d, input int hold);
      logic to_bus;
      bus_t b;
      int   stall_n, cyc, exp_stall;
      model_op(op, addr, wd, to_bus, b);
      if (to_bus) bus_q.push_back(b);
      exp_q.push_back(res_model);
      exp_stall = to_bus ? a + d + 3 : 1;
      next_a = a; next_d = d;
      drive_req(op, addr, wd);
      stall_n = 0; cyc = 0;
      forever begin
         @(negedge clk);
         if (state_dbg == 2'd3) break;
         if (d_stall) stall_n++;
         cyc++;
         if (cyc > 40) begin check("done_timeout", 32'd1, 32'd0); break; end
         @(posedge clk); #1;
      end
      check("stall_cycles", 32'(stall_n), 32'(exp_stall));
      check("stall_low_in_done", {31'd0, d_stall}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("done_hold_state", {30'd0, state_dbg}, 32'd3);
         check("done_hold_no_req", {31'd0, data_req}, 32'd0);
         check("done_hold_no_stall", {31'd0, d_stall}, 32'd0);
      end
      @(posedge clk); #1;
      M_ena = 1'b1;
      @(posedge clk); #1;
      M_ena = 1'b0; E_mem_en = 1'b0;
      @(negedge clk);
      check("idle_after_done", {30'd0, state_dbg}, 32'd0);
      check("result_held", M_mem_rdata, res_model);
      @(posedge clk); #1;
   endtask

   // Load killed by E_flush after flush_at cycles; it drains but leaves no trace.
   task automatic run_cancel(input logic [5:0] op, input logic [31:0] addr,
                             input int a, input int d, input int flush_at);
      bus_t        b;
      logic        to_bus, saved_ll;
      logic [31:0] saved_res;
      int          cyc;
      saved_res = res_model; saved_ll = ll_model;
      model_op(op, addr, 32'd0, to_bus, b);
      res_model = saved_res; ll_model = saved_ll;
      bus_q.push_back(b);
      next_a = a; next_d = d;
      drive_req(op, addr, 32'd0);
      for (int k = 0; k < flush_at; k++) begin @(posedge clk); #1; end
      E_flush = 1'b1;
      @(posedge clk); #1;
      E_flush = 1'b0; E_mem_en = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (state_dbg == 2'd0) break;
         if (state_dbg == 2'd3) begin check("cancel_reached_done", 32'd1, 32'd0); break; end
         cyc++;
         if (cyc > 40) begin check("cancel_timeout", 32'd1, 32'd0); break; end
         @(posedge clk); #1;
      end
      check("cancel_result_kept", M_mem_rdata, res_model);
      check("cancel_bus_drained", 32'(bus_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_llclr();
      llbit_clr = 1'b1; ll_model = 1'b0;
      @(posedge clk); #1;
      llbit_clr = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [5:0]  ops[10];
      logic [5:0]  op;
      logic [31:0] addr;
      ops = '{`OP_LB, `OP_LBU, `OP_LH, `OP_LHU, `OP_LW, `OP_LL, `OP_SB, `OP_SH, `OP_SW, `OP_SC};
      for (int i = 0; i < 128; i++) begin
         ref_mem[i] = $urandom; bus_mem[i] = ref_mem[i];
      end
      ref_mem[0] = 32'h80FF_FF12; bus_mem[0] = 32'h80FF_FF12;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", {30'd0, state_dbg}, 32'd0);
      check("rst_req_wr", {30'd0, data_req, data_wr}, 32'd0);
      check("rst_size_wstrb", {26'd0, data_size, data_wstrb}, 32'd0);
      check("rst_addr", data_addr, 32'd0);
      check("rst_wdata", data_wdata, 32'd0);
      check("rst_result", M_mem_rdata, 32'd0);
      check("rst_stall", {31'd0, d_stall}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(`OP_LB,  32'h0000_0003, 32'd0, 0, 0, 0);
      run_op(`OP_LBU, 32'h0000_0003, 32'd0, 0, 0, 0);
      run_op(`OP_SH,  32'h0000_0012, 32'h0000_BEEF, 0, 0, 0);
      run_op(`OP_LW,  32'h0000_0010, 32'd0, 3, 0, 0);
      run_op(`OP_LL,  32'h0000_0100, 32'd0, 0, 0, 0);
      run_op(`OP_SC,  32'h0000_0100, 32'd5, 0, 0, 0);
      run_op(`OP_LL,  32'h0000_0100, 32'd0, 1, 1, 0);
      pulse_llclr();
      run_op(`OP_SC,  32'h0000_0100, 32'd9, 0, 0, 0);
      run_op(`OP_LL,  32'h0000_0104, 32'd0, 0, 0, 0);
      run_cancel(`OP_LW, 32'h0000_0008, 0, 3, 3);
      run_op(`OP_SC,  32'h0000_0104, 32'd7, 0, 0, 0);
      pulse_llclr();
      run_cancel(`OP_LL, 32'h0000_0108, 1, 1, 2);
      run_op(`OP_SC,  32'h0000_0108, 32'd3, 0, 0, 0);

      // Killed instruction in IDLE: no stall, no bus access.
      drive_req(`OP_LW, 32'h0000_0020, 32'd0);
      E_flush = 1'b1;
      @(negedge clk);
      check("flush_idle_stall", {31'd0, d_stall}, 32'd0);
      @(posedge clk); #1;
      E_flush = 1'b0; E_mem_en = 1'b0;
      @(negedge clk);
      check("flush_idle_state", {30'd0, state_dbg}, 32'd0);
      check("flush_idle_no_req", {31'd0, data_req}, 32'd0);
      @(posedge clk); #1;

      run_op(`OP_LW, 32'h0000_0024, 32'd0, 0, 0, 2);

      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 9)];
         addr = 32'($urandom_range(0, 127)) * 4;
         if (op == `OP_LB || op == `OP_LBU || op == `OP_SB) addr += 32'($urandom_range(0, 3));
         else if (op == `OP_LH || op == `OP_LHU || op == `OP_SH) addr += 32'($urandom_range(0, 1)) * 2;
         if ($urandom_range(0, 7) == 0) pulse_llclr();
         run_op(op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("bus_q_empty", 32'(bus_q.size()), 32'd0);

      // Asynchronous reset while a request is waiting for addr_ok.
      next_a = 3; next_d = 0;
      drive_req(`OP_LW, 32'h0000_0010, 32'd0);
      @(posedge clk); #1;
      E_mem_en = 1'b0;
      @(negedge clk);
      check("pre_reset_req", {31'd0, data_req}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("async_rst_state", {30'd0, state_dbg}, 32'd0);
      check("async_rst_req", {31'd0, data_req}, 32'd0);
      check("async_rst_stall", {31'd0, d_stall}, 32'd0);
      check("async_rst_result", M_mem_rdata, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus_q.delete(); exp_q.delete();
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
